irq_pending_ctrl: RTL and testbench

IRQ_PENDING_CTRL -- requirements
Module: irq_pending_ctrl

---
 rtl/irq_pending_ctrl_pkg.sv | 20 ++
 rtl/irq_pending_ctrl_if.sv | 23 ++
 rtl/irq_pending_ctrl_enc.sv | 24 ++
 rtl/irq_pending_ctrl.sv | 84 ++++++++
 tb/tb_irq_pending_ctrl.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/irq_pending_ctrl_pkg.sv
// Shared constants, FSM state type and id decode helper for irq_pending_ctrl.
// Eight request lines, 3-bit id.
package irq_pkg;

    localparam int NUM_IRQ = 8;
    localparam int ID_W    = 3;

    typedef enum logic {
        IDLE    = 1'b0,
        PRESENT = 1'b1
    } state_e;

    function automatic logic [NUM_IRQ-1:0] id_onehot(input logic [ID_W-1:0] id);
        logic [NUM_IRQ-1:0] r;
        r     = '0;
        r[id] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/irq_pending_ctrl_if.sv
// Request/presentation bundle for irq_pending_ctrl.
// slave: irq_in, irq_mask, ack in; irq_valid, irq_id, pending out.
interface irq_pending_ctrl_if;
    import irq_pkg::*;

    logic [NUM_IRQ-1:0] irq_in;
    logic [NUM_IRQ-1:0] irq_mask;
    logic               ack;
    logic               irq_valid;
    logic [ID_W-1:0]    irq_id;
    logic [NUM_IRQ-1:0] pending;

    modport master (
        output irq_in, irq_mask, ack,
        input  irq_valid, irq_id, pending
    );

    modport slave (
        input  irq_in, irq_mask, ack,
        output irq_valid, irq_id, pending
    );

endinterface

// File: rtl/irq_pending_ctrl_enc.sv
// 8-to-3 priority encoder, bit 7 highest.
// Ports: ei_i enable, d_i lines, y_o index, gs_o any-line-active.
module encoder_83 (
    input  logic       ei_i,
    input  logic [7:0] d_i,
    output logic [2:0] y_o,
    output logic       gs_o
);

    always_comb begin
        y_o  = '0;
        gs_o = 1'b0;
        if (ei_i) begin
            // ascending scan: the last hit is the highest line
            for (int i = 0; i < 8; i++) begin
                if (d_i[i]) begin
                    y_o  = i[2:0];
                    gs_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/irq_pending_ctrl.sv
// Latches interrupt requests into a pending vector and presents the highest
// unmasked one (id + valid) until acked. Ports: clk, rst_n, bus (slave).
// Macro IRQ_EDGE_DET_EN: rising-edge events; undefined: level events.
module irq_pending_ctrl
    import irq_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    irq_pending_ctrl_if.slave  bus
);

    logic [NUM_IRQ-1:0] pend_q;
    logic [NUM_IRQ-1:0] pend_d;
    logic [NUM_IRQ-1:0] evt;
    logic [NUM_IRQ-1:0] clr;
    logic [NUM_IRQ-1:0] cand;
    logic [ID_W-1:0]    id_q;
    logic [ID_W-1:0]    enc_y;
    logic               valid_q;
    logic               gs;
    state_e             state_q;

`ifdef IRQ_EDGE_DET_EN
    logic [NUM_IRQ-1:0] prev_q;

    // prev resets low so a line held across reset yields an event
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) prev_q <= '0;
        else        prev_q <= bus.irq_in;
    end

    assign evt = bus.irq_in & ~prev_q;
`else
    assign evt = bus.irq_in;
`endif

    assign clr    = (valid_q && bus.ack) ? id_onehot(id_q) : '0;
    // set wins over a same-cycle clear
    assign pend_d = (pend_q & ~clr) | evt;
    assign cand   = pend_q & ~bus.irq_mask;

    encoder_83 u_enc (
        .ei_i (1'b1),
        .d_i  (cand),
        .y_o  (enc_y),
        .gs_o (gs)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
            id_q    <= '0;
            pend_q  <= '0;
        end else begin
            pend_q <= pend_d;
            case (state_q)
                IDLE: begin
                    if (gs) begin
                        state_q <= PRESENT;
                        valid_q <= 1'b1;
                        id_q    <= enc_y;
                    end
                end
                PRESENT: begin
                    // no retraction or pre-emption until acked
                    if (bus.ack) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.irq_valid = valid_q;
    assign bus.irq_id    = id_q;
    assign bus.pending   = pend_q;

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Directed vector bench for irq_pending_ctrl.
// Expectations cover both event modes via IRQ_EDGE_DET_EN.
module tb_irq_pending_ctrl;

    logic clk;
    logic rst_n;
    int   nvec;
    int   nfail;

    irq_pending_ctrl_if bus();

    irq_pending_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] in;
        logic [7:0] mask;
        logic       ack;
        logic       v;
        logic [2:0] id;
        logic [7:0] p;
    } vec_t;

    vec_t tbl[22];

    function automatic vec_t mk(logic [7:0] in, logic [7:0] mask, logic ack,
                                logic v, logic [2:0] id, logic [7:0] p);
        vec_t r;
        r.in = in; r.mask = mask; r.ack = ack;
        r.v = v; r.id = id; r.p = p;
        return r;
    endfunction

    task automatic chk(string name, logic [7:0] act, logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic chk_all(string tag, logic v, logic [2:0] id, logic [7:0] p);
        chk({tag, ".valid"}, {7'd0, bus.irq_valid}, {7'd0, v});
        chk({tag, ".id"}, {5'd0, bus.irq_id}, {5'd0, id});
        chk({tag, ".pending"}, bus.pending, p);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_all("reset", 1'b0, 3'd0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        nvec  = 0;
        nfail = 0;
        rst_n = 1'b0;
        bus.irq_in   = '0;
        bus.irq_mask = '0;
        bus.ack      = 1'b0;

        //         in     mask   ack   v     id    pend
        tbl[0]  = mk(8'h00, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        tbl[1]  = mk(8'h24, 8'h00, 1'b0, 1'b0, 3'd0, 8'h24);
        tbl[2]  = mk(8'h00, 8'h00, 1'b0, 1'b1, 3'd5, 8'h24);
        tbl[3]  = mk(8'h00, 8'h00, 1'b1, 1'b0, 3'd5, 8'h04);
        tbl[4]  = mk(8'h00, 8'h00, 1'b0, 1'b1, 3'd2, 8'h04);
        tbl[5]  = mk(8'h80, 8'h00, 1'b0, 1'b1, 3'd2, 8'h84);
        tbl[6]  = mk(8'h00, 8'h00, 1'b0, 1'b1, 3'd2, 8'h84);
        tbl[7]  = mk(8'h00, 8'h00, 1'b1, 1'b0, 3'd2, 8'h80);
        tbl[8]  = mk(8'h00, 8'h00, 1'b0, 1'b1, 3'd7, 8'h80);
        tbl[9]  = mk(8'h00, 8'h00, 1'b1, 1'b0, 3'd7, 8'h00);
        tbl[10] = mk(8'h00, 8'h00, 1'b1, 1'b0, 3'd7, 8'h00);
        tbl[11] = mk(8'h81, 8'h80, 1'b0, 1'b0, 3'd7, 8'h81);
        tbl[12] = mk(8'h00, 8'h80, 1'b0, 1'b1, 3'd0, 8'h81);
        tbl[13] = mk(8'h00, 8'h80, 1'b1, 1'b0, 3'd0, 8'h80);
        tbl[14] = mk(8'h00, 8'h80, 1'b0, 1'b0, 3'd0, 8'h80);
        tbl[15] = mk(8'h00, 8'h00, 1'b0, 1'b1, 3'd7, 8'h80);
        tbl[16] = mk(8'h00, 8'h00, 1'b1, 1'b0, 3'd7, 8'h00);
        tbl[17] = mk(8'h08, 8'h00, 1'b0, 1'b0, 3'd7, 8'h08);
        tbl[18] = mk(8'h00, 8'h00, 1'b0, 1'b1, 3'd3, 8'h08);
        tbl[19] = mk(8'h08, 8'h00, 1'b1, 1'b0, 3'd3, 8'h08);
        tbl[20] = mk(8'h00, 8'h00, 1'b0, 1'b1, 3'd3, 8'h08);
        tbl[21] = mk(8'h00, 8'h00, 1'b1, 1'b0, 3'd3, 8'h00);

        #2;
        chk_all("por", 1'b0, 3'd0, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            bus.irq_in   = tbl[i].in;
            bus.irq_mask = tbl[i].mask;
            bus.ack      = tbl[i].ack;
            step();
            chk_all($sformatf("vec%0d", i), tbl[i].v, tbl[i].id, tbl[i].p);
        end

        // async reset in the middle of a presentation
        bus.irq_in = 8'h02;
        bus.ack    = 1'b0;
        step();
        bus.irq_in = 8'h00;
        step();
        chk_all("pre_rst", 1'b1, 3'd1, 8'h02);
        #4;
        rst_n = 1'b0;
        #1;
        chk_all("mid_rst", 1'b0, 3'd0, 8'h00);

        // line held high across reset release
        bus.irq_in = 8'h10;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_all("hold_evt", 1'b0, 3'd0, 8'h10);
        step();
        chk_all("hold_gnt", 1'b1, 3'd4, 8'h10);
        bus.ack = 1'b1;
        step();
`ifdef IRQ_EDGE_DET_EN
        chk_all("hold_ack", 1'b0, 3'd4, 8'h00);
`else
        chk_all("hold_ack", 1'b0, 3'd4, 8'h10);
`endif
        bus.ack = 1'b0;
        step();
`ifdef IRQ_EDGE_DET_EN
        chk_all("hold_idle", 1'b0, 3'd4, 8'h00);
`else
        chk_all("hold_regnt", 1'b1, 3'd4, 8'h10);
`endif

        // line 0 held with ack always asserted
        bus.irq_in = 8'h00;
        do_reset();
        bus.irq_in = 8'h01;
        bus.ack    = 1'b1;
        step();
        chk_all("lvl1", 1'b0, 3'd0, 8'h01);
        for (int k = 2; k <= 7; k++) begin
`ifdef IRQ_EDGE_DET_EN
            if (k == 2) chk_all("lvl_k", 1'b0, 3'd0, 8'h01);
            step();
            chk_all($sformatf("edge%0d", k), (k == 2), 3'd0,
                    (k == 2) ? 8'h01 : 8'h00);
`else
            step();
            chk_all($sformatf("lvl%0d", k), (k % 2 == 0), 3'd0, 8'h01);
`endif
        end

        bus.ack    = 1'b0;
        bus.irq_in = 8'h00;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
